// File: rtl/zbt_arbiter_if.sv
// zbt_arbiter_if: requester, write-queue and ZBT memory signals of the arbiter
interface zbt_arbiter_if #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 36,
    parameter int WF_DEPTH = 4
);
    localparam int LW = $clog2(WF_DEPTH) + 1;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [LW-1:0]     wr_level;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
        output rd_gnt, rd_data, rd_valid, wr_ready, wr_level, mem_addr, mem_we, mem_wdata
    );
    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
        input  rd_gnt, rd_data, rd_valid, wr_ready, wr_level, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/zbt_arbiter.sv
// zbt_arbiter: single-port ZBT arbiter, read priority with a posted-write FIFO
module zbt_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 36,
    parameter int RD_LAT   = 2,
    parameter int WF_DEPTH = 4
) (
    input logic clock,
    input logic reset,
    zbt_arbiter_if.slave bus
);
    localparam int PW = $clog2(WF_DEPTH);
    localparam int LW = PW + 1;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FORCE_WR} slot_t;
    logic [ADDR_W-1:0] fa [WF_DEPTH];
    logic [DATA_W-1:0] fd [WF_DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [LW-1:0]     level;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, rd_data;
    logic              mem_we, rd_valid;
    logic [RD_LAT:0]   vld;
    logic              full, rd_gnt, wr_ready, push, pop;
    slot_t             slot;
    always_comb begin
        full     = level == LW'(WF_DEPTH);
        rd_gnt   = !reset && bus.rd_req && !full;
        wr_ready = !reset && !full;
        push     = bus.wr_req && wr_ready;
        slot     = full ? FORCE_WR : bus.rd_req ? READ : (level != '0) ? DRAIN : IDLE;
        pop      = !reset && (slot == FORCE_WR || slot == DRAIN);
    end
    // FIFO storage needs no reset; occupancy and pointers define validity
    always_ff @(posedge clock) begin
        if (push) begin
            fa[wp] <= bus.wr_addr;
            fd[wp] <= bus.wr_data;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            vld       <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level  <= level + LW'(push) - LW'(pop);
            mem_we <= pop;
            if (pop) begin
                mem_addr  <= fa[rp];
                mem_wdata <= fd[rp];
            end else if (rd_gnt) begin
                mem_addr <= bus.rd_addr;
            end
            // valid bit reaches the top RD_LAT edges after issue; data is sampled one edge later
            vld      <= {vld[RD_LAT-1:0], rd_gnt};
            rd_valid <= vld[RD_LAT];
            if (vld[RD_LAT]) rd_data <= bus.mem_rdata;
        end
    end
    assign bus.rd_gnt    = rd_gnt;
    assign bus.wr_ready  = wr_ready;
    assign bus.wr_level  = level;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = mem_wdata;
    assign bus.rd_data   = rd_data;
    assign bus.rd_valid  = rd_valid;
endmodule

// File: tb/tb_zbt_arbiter.sv
// tb_zbt_arbiter: directed stimulus with a queue scoreboard for reads and issued writes
module tb_zbt_arbiter;
    localparam int ADDR_W = 19, DATA_W = 36, RD_LAT = 2, WF_DEPTH = 4;
    typedef struct {logic [DATA_W-1:0] data; int cyc;} rd_exp_t;
    typedef struct {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} wr_exp_t;
    logic clock = 0, reset = 1;
    int tests = 0, fails = 0, cyc = 0, run = 0, max_run = 0, vcnt = 0, wcnt = 0;
    rd_exp_t rq[$];
    wr_exp_t wq[$];
    logic [ADDR_W-1:0] ap [RD_LAT];
    zbt_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WF_DEPTH(WF_DEPTH)) bus ();
    zbt_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .WF_DEPTH(WF_DEPTH)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    always #5 clock = ~clock;
    function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return (a == 19'h00100) ? 36'hABCDE0123 : {a[17:0], ~a[17:0]};
    endfunction
    // memory model: address sampled at the edge after issue, data out RD_LAT edges after issue
    always @(posedge clock) begin
        cyc <= cyc + 1;
        ap[0] <= bus.mem_addr;
        for (int i = 1; i < RD_LAT; i++) ap[i] <= ap[i-1];
    end
    assign bus.mem_rdata = mem_fn(ap[RD_LAT-1]);
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    always @(negedge clock) begin
        if (reset) begin
            rq.delete();
            wq.delete();
            run = 0;
        end else begin
            if (bus.rd_valid) begin
                vcnt++;
                run++;
                if (run > max_run) max_run = run;
                if (rq.size() == 0) check("rd_valid_unexpected", 1, 0);
                else begin
                    check("rd_data", bus.rd_data, rq[0].data);
                    check("rd_latency", cyc, rq[0].cyc);
                    void'(rq.pop_front());
                end
            end else begin
                run = 0;
                if (rq.size() != 0 && rq[0].cyc <= cyc) begin
                    check("rd_valid_missing", 0, 1);
                    void'(rq.pop_front());
                end
            end
            if (bus.mem_we) begin
                wcnt++;
                if (wq.size() == 0) check("mem_we_unexpected", 1, 0);
                else begin
                    check("wr_addr", bus.mem_addr, wq[0].addr);
                    check("wr_data", bus.mem_wdata, wq[0].data);
                    void'(wq.pop_front());
                end
            end
            if (bus.rd_req && bus.rd_gnt) rq.push_back('{mem_fn(bus.rd_addr), cyc + RD_LAT + 2});
            if (bus.wr_req && bus.wr_ready) wq.push_back('{bus.wr_addr, bus.wr_data});
        end
    end
    initial begin
        int v0, w0;
        bus.rd_req = 1; bus.rd_addr = 19'h00123; bus.wr_req = 1; bus.wr_addr = 19'h7; bus.wr_data = 36'h9;
        repeat (2) @(negedge clock);
        check("rst_rd_gnt", bus.rd_gnt, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        bus.rd_req = 0; bus.wr_req = 0;
        tick();
        reset = 0;
        @(negedge clock);
        check("rel_wr_ready", bus.wr_ready, 1);
        check("rel_wr_level", bus.wr_level, 0);
        tick();
        // single read
        bus.rd_req = 1; bus.rd_addr = 19'h00100;
        #1 check("single_gnt", bus.rd_gnt, 1);
        tick();
        bus.rd_req = 0;
        check("single_mem_addr", bus.mem_addr, 19'h00100);
        check("single_mem_we", bus.mem_we, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("single_valid_timing", bus.rd_valid, i == RD_LAT + 1);
            if (i == RD_LAT + 1) check("single_rd_data", bus.rd_data, 36'hABCDE0123);
        end
        tick();
        // write latency into empty FIFO
        bus.wr_req = 1; bus.wr_addr = 19'h01234; bus.wr_data = 36'h55;
        tick();
        bus.wr_req = 0;
        check("wlat_not_yet", bus.mem_we, 0);
        tick();
        check("wlat_we", bus.mem_we, 1);
        check("wlat_addr", bus.mem_addr, 19'h01234);
        tick();
        // priority: writes wait while reads are requested
        bus.rd_req = 1; bus.rd_addr = 19'h00200;
        bus.wr_req = 1; bus.wr_addr = 19'h40000; bus.wr_data = 36'h1;
        tick();
        bus.wr_req = 0;
        for (int i = 0; i < 4; i++) begin
            check("prio_no_write", bus.mem_we, 0);
            tick();
        end
        bus.rd_req = 0;
        tick();
        check("prio_we", bus.mem_we, 1);
        check("prio_addr", bus.mem_addr, 19'h40000);
        check("prio_wdata", bus.mem_wdata, 36'h1);
        tick();
        check("prio_idle_we", bus.mem_we, 0);
        check("prio_level", bus.wr_level, 0);
        // force write on full FIFO
        bus.rd_req = 1; bus.rd_addr = 19'h00300;
        for (int i = 0; i < 4; i++) begin
            bus.wr_req = 1; bus.wr_addr = 19'h50000 + 19'(i); bus.wr_data = 36'h100 + 36'(i);
            tick();
        end
        bus.wr_req = 0;
        check("full_level", bus.wr_level, 4);
        check("full_ready", bus.wr_ready, 0);
        check("full_gnt", bus.rd_gnt, 0);
        tick();
        check("force_we", bus.mem_we, 1);
        check("force_addr", bus.mem_addr, 19'h50000);
        check("force_wdata", bus.mem_wdata, 36'h100);
        check("force_level", bus.wr_level, 3);
        check("force_gnt_back", bus.rd_gnt, 1);
        tick();
        check("resume_we", bus.mem_we, 0);
        check("resume_addr", bus.mem_addr, 19'h00300);
        bus.rd_req = 0;
        repeat (8) tick();
        // back-to-back reads
        max_run = 0; v0 = vcnt;
        for (int i = 0; i < 16; i++) begin
            bus.rd_req = 1; bus.rd_addr = 19'(i);
            tick();
        end
        bus.rd_req = 0;
        repeat (6) tick();
        check("b2b_run", max_run, 16);
        check("b2b_count", vcnt - v0, 16);
        // reset with reads in flight and a queued write
        bus.rd_req = 1; bus.rd_addr = 19'h00010;
        bus.wr_req = 1; bus.wr_addr = 19'h60000; bus.wr_data = 36'h7;
        tick();
        bus.rd_addr = 19'h00011; bus.wr_req = 0;
        tick();
        bus.rd_req = 0;
        reset = 1;
        v0 = vcnt; w0 = wcnt;
        repeat (2) tick();
        reset = 0;
        #1 check("mid_level", bus.wr_level, 0);
        repeat (10) tick();
        check("mid_no_valid", vcnt - v0, 0);
        check("mid_no_we", wcnt - w0, 0);
        for (int i = 0; i < 50 && (rq.size() != 0 || wq.size() != 0); i++) tick();
        check("drain_empty", rq.size() + wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
